// File: rtl/imm_extend_pipe.sv
// RISC-V immediate generator: extracts I/S/B/U/J/Z immediates and sign/zero-extends to XLEN, optional negate.
// Latency: 2 cycles (stage 1 extract/extend, stage 2 negate/output); 1 result per cycle sustained.
// Backpressure: valid/ready; holds up to 2 entries; i_flush drops both. Build with IMM_NEG_EN to honour i_neg.
module imm_extend_pipe #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_flush,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [31:0]     i_instr,
    input  logic [2:0]      i_fmt,
    input  logic            i_uns,
    input  logic            i_neg,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_imm,
    output logic            o_err
);

    localparam logic [2:0] FMT_I = 3'd0;
    localparam logic [2:0] FMT_S = 3'd1;
    localparam logic [2:0] FMT_B = 3'd2;
    localparam logic [2:0] FMT_U = 3'd3;
    localparam logic [2:0] FMT_J = 3'd4;
    localparam logic [2:0] FMT_Z = 3'd5;

    logic            r_s1_vld;
    logic [XLEN-1:0] r_s1_ext;
    logic            r_s1_err;
    logic            r_s2_vld;
    logic [XLEN-1:0] r_s2_imm;
    logic            r_s2_err;

    logic            w_sx;
    logic [31:0]     w_u_fld;
    logic [XLEN-1:0] w_ext;
    logic            w_err;
    logic [XLEN-1:0] w_s2_val;
    logic            w_s2_open;
    logic            w_s1_open;

    // Stage 2 can take new data when empty or its output leaves this edge;
    // stage 1 likewise when empty or draining into stage 2.
    assign w_s2_open  = !r_s2_vld || i_out_ready;
    assign w_s1_open  = !r_s1_vld || w_s2_open;
    assign o_in_ready = !i_flush && w_s1_open;

    // Sign bit source is gated by UNS; U and Z ignore it below.
    assign w_sx    = !i_uns && i_instr[31];
    assign w_u_fld = {i_instr[31:12], 12'b0};

    // Field extraction and extension per instruction format.
    always_comb begin
        w_ext = '0;
        w_err = 1'b0;
        case (i_fmt)
            FMT_I: w_ext = {{(XLEN-12){w_sx}}, i_instr[31:20]};
            FMT_S: w_ext = {{(XLEN-12){w_sx}}, i_instr[31:25], i_instr[11:7]};
            FMT_B: w_ext = {{(XLEN-13){w_sx}}, i_instr[31], i_instr[7],
                            i_instr[30:25], i_instr[11:8], 1'b0};
            FMT_U: w_ext = {{(XLEN-31){w_u_fld[31]}}, w_u_fld[30:0]};
            FMT_J: w_ext = {{(XLEN-21){w_sx}}, i_instr[31], i_instr[19:12],
                            i_instr[20], i_instr[30:21], 1'b0};
            FMT_Z: w_ext = {{(XLEN-5){1'b0}}, i_instr[19:15]};
            default: begin
                w_ext = '0;
                w_err = 1'b1;
            end
        endcase
    end

`ifdef IMM_NEG_EN
    logic r_s1_neg;
    logic w_unused_bits;

    // Opcode bits never feed an immediate.
    assign w_unused_bits = ^i_instr[6:0];

    // Two's-complement negate; wraps, so the most-negative value maps to itself.
    assign w_s2_val = r_s1_neg ? (~r_s1_ext + XLEN'(1)) : r_s1_ext;

    // Negate request travels with its entry through stage 1.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_s1_neg <= 1'b0;
        end else if (!i_flush && w_s1_open && i_in_valid) begin
            r_s1_neg <= i_neg;
        end
    end
`else
    logic w_unused_bits;

    // Negate disabled: NEG is ignored and stage 2 is a plain register.
    assign w_unused_bits = ^{i_instr[6:0], i_neg};
    assign w_s2_val      = r_s1_ext;
`endif

    // Stage 1: capture the extended immediate of an accepted input.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_s1_vld <= 1'b0;
            r_s1_ext <= '0;
            r_s1_err <= 1'b0;
        end else if (i_flush) begin
            r_s1_vld <= 1'b0;
        end else if (w_s1_open) begin
            r_s1_vld <= i_in_valid;
            if (i_in_valid) begin
                r_s1_ext <= w_ext;
                r_s1_err <= w_err;
            end
        end
    end

    // Stage 2: output register; holds stable while the consumer stalls,
    // and is cleared on flush so no dropped value is left on the bus.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_s2_vld <= 1'b0;
            r_s2_imm <= '0;
            r_s2_err <= 1'b0;
        end else if (i_flush) begin
            r_s2_vld <= 1'b0;
            r_s2_imm <= '0;
            r_s2_err <= 1'b0;
        end else if (w_s2_open) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_imm <= w_s2_val;
                r_s2_err <= r_s1_err;
            end
        end
    end

    assign o_out_valid = r_s2_vld;
    assign o_imm       = r_s2_imm;
    assign o_err       = r_s2_err;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: formats, extension, negate, stall/hold, flush, async reset.
// Expected results are hand-computed per vector and queued on acceptance; the consumer side pops and compares.
// Backpressure exercised by driving i_out_ready low while pushing.
module tb_imm_extend_pipe;

    localparam int XLEN = 32;

`ifdef IMM_NEG_EN
    localparam logic [63:0] EXP_NEG5 = 64'h0000_0000_FFFF_FFFB;
`else
    localparam logic [63:0] EXP_NEG5 = 64'h0000_0000_0000_0005;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            i_flush;
    logic            i_in_valid;
    logic            o_in_ready;
    logic [31:0]     i_instr;
    logic [2:0]      i_fmt;
    logic            i_uns;
    logic            i_neg;
    logic            o_out_valid;
    logic            i_out_ready;
    logic [XLEN-1:0] o_imm;
    logic            o_err;

    int          n_chk  = 0;
    int          n_err  = 0;
    int          n_wait = 0;
    logic [64:0] cur_exp;
    logic [64:0] exp_q[$];

    always #5 clk = ~clk;

    imm_extend_pipe #(.XLEN(XLEN)) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_flush     (i_flush),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_instr     (i_instr),
        .i_fmt       (i_fmt),
        .i_uns       (i_uns),
        .i_neg       (i_neg),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_imm       (o_imm),
        .o_err       (o_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Consumer-side scoreboard: accepted inputs queue their expected result,
    // transferred outputs pop and compare in order.
    always @(negedge clk) begin
        logic [64:0] e;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (o_out_valid && i_out_ready && !i_flush) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 64'(o_imm), 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_imm", 64'(o_imm), 64'(e[XLEN-1:0]));
                    chk("out_err", 64'(o_err), 64'(e[64]));
                end
            end
            if (i_flush) exp_q.delete();
            else if (i_in_valid && o_in_ready) exp_q.push_back(cur_exp);
        end
    end

    // Present one vector and hold it until accepted (bounded).
    task automatic drive(input logic [31:0] instr, input logic [2:0] fmt, input logic uns,
                         input logic neg, input logic [63:0] exp_imm, input logic exp_err);
        bit done = 1'b0;
        i_instr    = instr;
        i_fmt      = fmt;
        i_uns      = uns;
        i_neg      = neg;
        cur_exp    = {exp_err, exp_imm};
        i_in_valid = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (o_in_ready) done = 1'b1;
            else n_wait++;
            @(posedge clk);
            #1;
        end
        if (!done) chk("accept_timeout", 64'd0, 64'd1);
        i_in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 50; k++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        @(posedge clk);
        #1;
        chk("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        i_flush     = 1'b0;
        i_in_valid  = 1'b0;
        i_instr     = '0;
        i_fmt       = '0;
        i_uns       = 1'b0;
        i_neg       = 1'b0;
        i_out_ready = 1'b1;
        cur_exp     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(o_out_valid), 64'd0);
        chk("rst_imm", 64'(o_imm), 64'd0);
        chk("rst_err", 64'(o_err), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(o_in_ready), 64'd1);
        @(posedge clk);
        #1;

        // First transaction latency: captured at edge 1, visible after edge 2.
        drive(32'hFFF00093, 3'd0, 1'b0, 1'b0, 64'hFFFF_FFFF, 1'b0);
        @(negedge clk);
        chk("lat_edge1_valid", 64'(o_out_valid), 64'd0);
        @(negedge clk);
        chk("lat_edge2_valid", 64'(o_out_valid), 64'd1);
        chk("lat_edge2_imm", 64'(o_imm), 64'hFFFF_FFFF);
        chk("lat_edge2_err", 64'(o_err), 64'd0);
        drain();

        // Back-to-back stream with consumer always ready.
        n_wait = 0;
        drive(32'hFE000EE3, 3'd2, 1'b0, 1'b0, 64'hFFFF_FFFC, 1'b0); // B signed
        drive(32'hFE000EE3, 3'd2, 1'b1, 1'b0, 64'h0000_1FFC, 1'b0); // B zero-ext
        drive(32'h123450B7, 3'd3, 1'b0, 1'b0, 64'h1234_5000, 1'b0); // U
        drive(32'hFFFFF0B7, 3'd3, 1'b1, 1'b0, 64'hFFFF_F000, 1'b0); // U ignores UNS
        drive(32'hFE112E23, 3'd1, 1'b0, 1'b0, 64'hFFFF_FFFC, 1'b0); // S signed
        drive(32'hFE112E23, 3'd1, 1'b1, 1'b0, 64'h0000_0FFC, 1'b0); // S zero-ext
        drive(32'h800000EF, 3'd4, 1'b0, 1'b0, 64'hFFF0_0000, 1'b0); // J signed
        drive(32'h800000EF, 3'd4, 1'b1, 1'b0, 64'h0010_0000, 1'b0); // J zero-ext
        drive(32'h800F8073, 3'd5, 1'b0, 1'b0, 64'h0000_001F, 1'b0); // Z always zero-ext
        drive(32'hFFFFFFFF, 3'd6, 1'b0, 1'b0, 64'h0000_0000, 1'b1); // reserved
        drive(32'hFFFFFFFF, 3'd7, 1'b0, 1'b1, 64'h0000_0000, 1'b1); // reserved, negate of 0
        drive(32'h00500093, 3'd0, 1'b0, 1'b1, EXP_NEG5, 1'b0);     // NEG 5
        drive(32'h00000093, 3'd0, 1'b0, 1'b1, 64'h0000_0000, 1'b0); // NEG 0 -> 0
        drive(32'h80000037, 3'd3, 1'b0, 1'b1, 64'h8000_0000, 1'b0); // NEG most-negative
        chk("stream_stalls", 64'(n_wait), 64'd0);
        drain();

        // Stall: two entries fill the pipe, third is refused, output holds.
        i_out_ready = 1'b0;
        drive(32'h00100093, 3'd0, 1'b0, 1'b0, 64'h0000_0001, 1'b0);
        drive(32'h00200093, 3'd0, 1'b0, 1'b0, 64'h0000_0002, 1'b0);
        i_instr    = 32'h00300093;
        cur_exp    = {1'b0, 64'h3};
        i_in_valid = 1'b1;
        @(negedge clk);
        chk("full_in_ready", 64'(o_in_ready), 64'd0);
        chk("hold_valid", 64'(o_out_valid), 64'd1);
        chk("hold_imm", 64'(o_imm), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("hold2_in_ready", 64'(o_in_ready), 64'd0);
        chk("hold2_imm", 64'(o_imm), 64'd1);
        @(posedge clk);
        #1 i_out_ready = 1'b1;
        drive(32'h00300093, 3'd0, 1'b0, 1'b0, 64'h0000_0003, 1'b0);
        drain();

        // Flush with two in flight and a competing input.
        i_out_ready = 1'b0;
        drive(32'h00400093, 3'd0, 1'b0, 1'b0, 64'h0000_0004, 1'b0);
        drive(32'h00500093, 3'd0, 1'b0, 1'b0, 64'h0000_0005, 1'b0);
        i_flush     = 1'b1;
        i_out_ready = 1'b1;
        i_instr     = 32'h00600093;
        cur_exp     = {1'b0, 64'h6};
        i_in_valid  = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 64'(o_in_ready), 64'd0);
        @(posedge clk);
        #1;
        i_flush    = 1'b0;
        i_in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("flush_out_valid", 64'(o_out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        // Asynchronous reset mid-stream clears outputs before the next edge.
        i_out_ready = 1'b0;
        drive(32'hFFF00093, 3'd0, 1'b0, 1'b0, 64'hFFFF_FFFF, 1'b0);
        drive(32'hFFFFFFFF, 3'd6, 1'b0, 1'b0, 64'h0000_0000, 1'b1);
        chk("pre_rst_valid", 64'(o_out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(o_out_valid), 64'd0);
        chk("arst_imm", 64'(o_imm), 64'd0);
        chk("arst_err", 64'(o_err), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        i_out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(o_in_ready), 64'd1);
        chk("post_rst_valid", 64'(o_out_valid), 64'd0);
        @(posedge clk);
        #1;
        drive(32'h7FF00093, 3'd0, 1'b0, 1'b0, 64'h0000_07FF, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
